mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a single data-memory port between the CPU's M stage and an
// external loader/debug burst master.
//
// Ports
//   clk, reset                    clock and asynchronous active-low reset
//   cpu_req/we/adr/wd, cpu_rd     CPU memory access, load data back
//   cpu_stall                     CPU access not granted this cycle
//   ext_req/we/base/len/wd        external burst request (sampled in IDLE)
//   ext_gnt, ext_done, ext_rd     per-beat grant, end-of-burst pulse, read data
//   mem_we, mem_a, mem_wd, mem_rd data memory port (mem_rd is combinational)
//
// The CPU normally wins in IDLE. An external request that keeps losing is
// counted, and once it has been deferred WAIT_MAX times it wins over the CPU.
// During a burst the CPU gets one slot after every MAX_RUN consecutive beats
// if it is waiting.
module mem_arbiter #(
    parameter int MAX_RUN  = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_base,
    input  logic [3:0]  ext_len,
    input  logic [31:0] ext_wd,
    output logic        ext_gnt,
    output logic        ext_done,
    output logic [31:0] ext_rd,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int RW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXT_BURST = 2'd1,
        CPU_SLOT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     addr;
    logic [3:0]      len_q;
    logic            we_q;
    logic [3:0]      beat_cnt;
    logic [RW-1:0]   run_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            done_q;

    logic            ext_wins;
    logic            last_beat;
    logic            run_full;

    // The external master takes the bus from IDLE when the CPU is quiet or
    // when it has already been deferred the maximum number of times.
    assign ext_wins  = ext_req && (!cpu_req || (wait_cnt == WW'(WAIT_MAX)));
    assign last_beat = (beat_cnt == len_q);
    assign run_full  = (run_cnt == RW'(MAX_RUN - 1));

    assign cpu_rd   = mem_rd;
    assign ext_rd   = mem_rd;
    assign ext_done = done_q;

    // State and burst bookkeeping. run_cnt saturates at MAX_RUN-1 so that a
    // CPU request arriving late in a long uncontended run still gets its
    // slot after the next beat rather than waiting for a counter wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            beat_cnt <= '0;
            run_cnt  <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ext_wins) begin
                        addr     <= ext_base & 32'hFFFF_FFFC;
                        len_q    <= ext_len;
                        we_q     <= ext_we;
                        beat_cnt <= '0;
                        run_cnt  <= '0;
                        wait_cnt <= '0;
                    end else if (ext_req && cpu_req) begin
                        if (wait_cnt != WW'(WAIT_MAX)) begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                EXT_BURST: begin
                    addr     <= addr + 32'd4;
                    beat_cnt <= beat_cnt + 4'd1;
                    if (!run_full) begin
                        run_cnt <= run_cnt + RW'(1);
                    end
                    if (last_beat) begin
                        done_q <= 1'b1;
                    end
                end
                CPU_SLOT: begin
                    run_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and memory port steering. The CPU's address and data sit on
    // the port by default; mem_we is only raised for a granted writer.
    always_comb begin
        state_next = state;
        cpu_stall  = 1'b0;
        ext_gnt    = 1'b0;
        mem_we     = 1'b0;
        mem_a      = cpu_adr;
        mem_wd     = cpu_wd;
        case (state)
            IDLE: begin
                if (ext_wins) begin
                    state_next = EXT_BURST;
                    cpu_stall  = cpu_req;
                end else if (cpu_req) begin
                    mem_we = cpu_we;
                end
            end
            EXT_BURST: begin
                ext_gnt   = 1'b1;
                cpu_stall = cpu_req;
                mem_a     = addr;
                mem_we    = we_q;
                mem_wd    = ext_wd;
                if (last_beat) begin
                    state_next = IDLE;
                end else if (run_full && cpu_req) begin
                    state_next = CPU_SLOT;
                end
            end
            CPU_SLOT: begin
                state_next = EXT_BURST;
                mem_we     = cpu_req && cpu_we;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A small word memory stands in for the
// data memory. Burst scenarios push their expected beats (address, direction,
// data, cycle) into a queue as stimulus is set up and pop them as ext_gnt
// beats appear.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_base;
    logic [3:0]  ext_len;
    logic [31:0] ext_wd;
    logic        ext_gnt;
    logic        ext_done;
    logic [31:0] ext_rd;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] tbmem [256];

    mem_arbiter #(.MAX_RUN(4), .WAIT_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_base  (ext_base),
        .ext_len   (ext_len),
        .ext_wd    (ext_wd),
        .ext_gnt   (ext_gnt),
        .ext_done  (ext_done),
        .ext_rd    (ext_rd),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, write on the rising edge,
    // cleared while reset is held.
    assign mem_rd = tbmem[mem_a[9:2]];

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < 256; i++) tbmem[i] <= 32'h0;
        end else if (mem_we === 1'b1) begin
            tbmem[mem_a[9:2]] <= mem_wd;
        end
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wd = 0;
        ext_req = 1'b1; ext_we = 1'b1; ext_base = 32'h100; ext_len = 4'd3; ext_wd = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (ext_gnt !== 1'b0 || ext_done !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: gnt=%b done=%b we=%b stall=%b, want all 0",
                     ext_gnt, ext_done, mem_we, cpu_stall);
        end
        step();
        ext_req = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ext_gnt !== 1'b0 || ext_done !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: gnt=%b done=%b we=%b stall=%b, want all 0",
                     ext_gnt, ext_done, mem_we, cpu_stall);
        end
        step();
    endtask

    task automatic test_cpu_only();
        cpu_req = 1; cpu_we = 1; cpu_adr = 32'h40; cpu_wd = 32'hDEADBEEF; ext_req = 0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || cpu_stall !== 1'b0 || mem_a !== 32'h40 ||
            mem_wd !== 32'hDEADBEEF || ext_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_store: we=%b stall=%b a=%h wd=%h, want 1 0 00000040 deadbeef",
                     mem_we, cpu_stall, mem_a, mem_wd);
        end
        step();
        checks++;
        if (tbmem[8'h10] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL cpu_store_mem: mem[0x40]=%h, want deadbeef", tbmem[8'h10]);
        end
        cpu_we = 0; cpu_wd = 0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || cpu_rd !== 32'hDEADBEEF || cpu_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_load: we=%b rd=%h stall=%b, want 0 deadbeef 0",
                     mem_we, cpu_rd, cpu_stall);
        end
        step();
        cpu_req = 0;
    endtask

    // Uncontended burst: beat k at base+4k in cycle k+1 after acceptance,
    // write data / expected read data dbase+k, ext_done in cycle len+2.
    task automatic test_burst(input string name, input logic [31:0] base,
                              input logic [3:0] len, input logic we, input logic [31:0] dbase);
        exp_t e;
        int   n;
        int   done_cyc;
        int   done_cnt;
        n = int'(len) + 1;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            e.a = base + 32'(4 * k); e.we = we; e.d = dbase + 32'(k); e.cyc = k + 1;
            exp_q.push_back(e);
        end
        cpu_req = 0; ext_req = 1; ext_we = we; ext_base = base; ext_len = len; ext_wd = 0;
        @(negedge clk);
        checks++;
        if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_accept: gnt=%b stall=%b, want 0 0", name, ext_gnt, cpu_stall);
        end
        step();
        ext_req = 0; ext_we = ~we; ext_base = 32'hDEAD0000; ext_len = 4'd0;
        done_cyc = -1; done_cnt = 0;
        for (int cyc = 1; cyc <= n + 4; cyc++) begin
            ext_wd = dbase + 32'(cyc - 1);
            @(negedge clk);
            if (ext_gnt === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s_extra_beat: cycle %0d a=%h, want no beat", name, cyc, mem_a);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_a !== e.a || mem_we !== e.we || cyc != e.cyc ||
                        (e.we && mem_wd !== e.d) || (!e.we && ext_rd !== e.d)) begin
                        errors++;
                        $display("[TB] FAIL %s_beat: cyc=%0d a=%h we=%b wd=%h rd=%h, want cyc=%0d a=%h we=%b data=%h",
                                 name, cyc, mem_a, mem_we, mem_wd, ext_rd, e.cyc, e.a, e.we, e.d);
                    end
                end
            end
            if (ext_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            step();
        end
        checks++;
        if (done_cyc != n + 1 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL %s_done: cycle %0d count %0d, want cycle %0d count 1",
                     name, done_cyc, done_cnt, n + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_missing: %0d beats never granted, want 0", name, exp_q.size());
        end
    endtask

    // 16-beat write burst against a CPU that keeps loading: four beats,
    // one CPU slot, repeated; last beat in cycle 19, ext_done in cycle 20.
    task automatic test_contention();
        exp_t e;
        int   beats;
        int   done_cyc;
        logic exp_slot;
        logic exp_stall;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            e.a = 32'h300 + 32'(4 * k); e.we = 1'b1; e.d = 32'h1000 + 32'(k); e.cyc = k + k / 4 + 1;
            exp_q.push_back(e);
        end
        cpu_req = 0; cpu_we = 0; cpu_adr = 32'h40; cpu_wd = 0;
        ext_req = 1; ext_we = 1; ext_base = 32'h300; ext_len = 4'd15; ext_wd = 0;
        @(negedge clk);
        step();
        ext_req = 0; cpu_req = 1;
        beats = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            ext_wd = 32'h1000 + 32'(beats);
            @(negedge clk);
            exp_slot  = (cyc <= 19) && (cyc % 5 == 0);
            exp_stall = (cyc <= 19) && !exp_slot;
            checks++;
            if (cpu_stall !== exp_stall) begin
                errors++;
                $display("[TB] FAIL contention_stall: cycle %0d stall=%b, want %b", cyc, cpu_stall, exp_stall);
            end
            if (exp_slot) begin
                checks++;
                if (ext_gnt !== 1'b0 || mem_a !== 32'h40 || mem_we !== 1'b0 || cpu_rd !== 32'hDEADBEEF) begin
                    errors++;
                    $display("[TB] FAIL contention_slot: cycle %0d gnt=%b a=%h we=%b rd=%h, want 0 00000040 0 deadbeef",
                             cyc, ext_gnt, mem_a, mem_we, cpu_rd);
                end
            end
            if (ext_gnt === 1'b1) begin
                beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL contention_extra_beat: cycle %0d, want no beat", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_a !== e.a || mem_we !== 1'b1 || mem_wd !== e.d || cyc != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL contention_beat: cyc=%0d a=%h wd=%h, want cyc=%0d a=%h wd=%h",
                                 cyc, mem_a, mem_wd, e.cyc, e.a, e.d);
                    end
                end
            end
            if (ext_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            step();
        end
        checks++;
        if (done_cyc != 20 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL contention_done: done cycle %0d, %0d beats left, want 20 and 0",
                     done_cyc, exp_q.size());
        end
        cpu_req = 0;
    endtask

    // A withdrawn request restarts the deferral count; then a held request
    // loses 8 times to the CPU and is accepted on the 9th IDLE cycle.
    task automatic test_starvation();
        int wins;
        int stall_cyc;
        int gnt_cyc;
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h40;
        ext_we = 0; ext_base = 32'h500; ext_len = 4'd0; ext_req = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (cpu_stall !== 1'b0 || mem_a !== 32'h40) begin
                errors++;
                $display("[TB] FAIL starve_early: cycle %0d stall=%b a=%h, want 0 00000040", c, cpu_stall, mem_a);
            end
            step();
        end
        ext_req = 0;
        @(negedge clk);
        step();
        ext_req = 1;
        wins = 0; stall_cyc = -1; gnt_cyc = -1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (cpu_stall === 1'b0 && ext_gnt === 1'b0 && stall_cyc < 0) wins++;
            if (cpu_stall === 1'b1 && stall_cyc < 0) stall_cyc = cyc;
            if (ext_gnt === 1'b1 && gnt_cyc < 0) begin
                gnt_cyc = cyc;
                checks++;
                if (mem_a !== 32'h500) begin
                    errors++;
                    $display("[TB] FAIL starve_beat_addr: a=%h, want 00000500", mem_a);
                end
            end
            step();
            if (stall_cyc > 0) ext_req = 0;
        end
        checks++;
        if (wins != 8 || stall_cyc != 9 || gnt_cyc != 10) begin
            errors++;
            $display("[TB] FAIL starve_order: cpu wins %0d, accept cycle %0d, first beat %0d, want 8 9 10",
                     wins, stall_cyc, gnt_cyc);
        end
        cpu_req = 0; ext_req = 0;
    endtask

    // ext_req held across two 2-beat bursts: the second is accepted in the
    // ext_done cycle and beats the cycle after.
    task automatic test_back_to_back();
        exp_t     e;
        bit [7:0] gnt_pat;
        bit [7:0] done_pat;
        gnt_pat  = 8'h36;
        done_pat = 8'h48;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            e.cyc = (k < 2) ? k + 1 : k + 2;
            e.a = 32'h600 + 32'(4 * (k % 2)); e.we = 1'b1; e.d = 32'h2000 + 32'(e.cyc);
            exp_q.push_back(e);
        end
        cpu_req = 0; ext_we = 1; ext_base = 32'h600; ext_len = 4'd1;
        for (int c = 0; c < 8; c++) begin
            ext_req = (c < 6);
            ext_wd  = 32'h2000 + 32'(c);
            @(negedge clk);
            checks++;
            if (ext_gnt !== gnt_pat[c] || ext_done !== done_pat[c]) begin
                errors++;
                $display("[TB] FAIL b2b_pattern: cycle %0d gnt=%b done=%b, want %b %b",
                         c, ext_gnt, ext_done, gnt_pat[c], done_pat[c]);
            end
            if (ext_gnt === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (mem_a !== e.a || mem_wd !== e.d || c != e.cyc) begin
                    errors++;
                    $display("[TB] FAIL b2b_beat: cyc=%0d a=%h wd=%h, want cyc=%0d a=%h wd=%h",
                             c, mem_a, mem_wd, e.cyc, e.a, e.d);
                end
            end
            step();
        end
        ext_req = 0;
    endtask

    // Reset two beats into an 8-beat burst: no further beats, no ext_done,
    // and a fresh burst afterwards starts at its own base.
    task automatic test_reset_mid_burst();
        int done_seen;
        int gnt_seen;
        cpu_req = 0; ext_req = 1; ext_we = 1; ext_base = 32'h700; ext_len = 4'd7; ext_wd = 32'h3000;
        @(negedge clk);
        step();
        ext_req = 0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (ext_gnt !== 1'b1 || mem_a !== 32'h700 + 32'(4 * (c - 1))) begin
                errors++;
                $display("[TB] FAIL rst_mid_beat: cycle %0d gnt=%b a=%h, want 1 %h",
                         c, ext_gnt, mem_a, 32'h700 + 32'(4 * (c - 1)));
            end
            step();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ext_gnt !== 1'b0 || mem_we !== 1'b0 || ext_done !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_abort: gnt=%b we=%b done=%b stall=%b, want all 0",
                     ext_gnt, mem_we, ext_done, cpu_stall);
        end
        @(negedge clk);
        step();
        reset = 1'b1;
        done_seen = 0; gnt_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ext_done === 1'b1) done_seen++;
            if (ext_gnt === 1'b1) gnt_seen++;
            step();
        end
        checks++;
        if (done_seen != 0 || gnt_seen != 0) begin
            errors++;
            $display("[TB] FAIL rst_mid_quiet: done pulses %0d, beats %0d, want 0 0", done_seen, gnt_seen);
        end
        test_burst("post_reset", 32'h800, 4'd1, 1'b1, 32'h20);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_cpu_only();
        test_burst("ext_write", 32'h100, 4'd3, 1'b1, 32'h1);
        test_burst("ext_read", 32'h100, 4'd3, 1'b0, 32'h1);
        test_burst("wrap", 32'hFFFFFFF8, 4'd3, 1'b1, 32'h10);
        test_contention();
        test_starvation();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
